coin_credit_module: RTL

Upstream front end for the coffee machine datapath. Synchronises and debounces the raw coin, confirm and cancel switches, and accumulates credit in units of 100. It arbitrates purchase against the selected price and hands off a vend request with computed change via a req/ack handshake. It then holds until the brew sequence reports done.

---
 rtl/coin_credit_module.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/coin_credit_module.sv
// Coin credit front end: debounced switches, credit accumulation,
// purchase arbitration and vend req/ack handoff to the brew stage.
module coin_credit_module #(
  parameter int unsigned DEBOUNCE_CYCLES    = 500000,
  parameter int unsigned MAX_CREDIT         = 9,
  parameter int unsigned REFUND_HOLD_CYCLES = 150000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic       confirm,
  input  logic       cancel,
  input  logic [3:0] price,
  input  logic       vend_ack,
  input  logic       brew_done,
  output logic [3:0] credit,
  output logic [3:0] change,
  output logic       vend_req,
  output logic       busy,
  output logic       reject,
  output logic       insufficient,
  output logic [2:0] state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(REFUND_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_BREW   = 3'd3,
    ST_REFUND = 3'd4
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    level_q;
  logic [3:0]    ev_q;
  logic [DW-1:0] cnt_q [4];

  assign raw = {cancel, confirm, coin_500, coin_100};

  // ev_q fires on the same edge the debounced level rises
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      ev_q    <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i]   <= '0;
          level_q[i] <= sync2_q[i];
          ev_q[i]    <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  logic coin100_ev, coin500_ev, confirm_ev, cancel_ev, coin_any;

  assign coin100_ev = ev_q[0];
  assign coin500_ev = ev_q[1];
  assign confirm_ev = ev_q[2];
  assign cancel_ev  = ev_q[3];
  assign coin_any   = coin100_ev | coin500_ev;

  state_t        state_q, state_d;
  logic [3:0]    credit_q, credit_d;
  logic [3:0]    change_q, change_d;
  logic          vend_req_q, vend_req_d;
  logic          busy_q, busy_d;
  logic          reject_q, reject_d;
  logic          insuff_q, insuff_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [4:0]    sum;
  logic [4:0]    total;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      change_q   <= '0;
      vend_req_q <= 1'b0;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      insuff_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      vend_req_q <= vend_req_d;
      busy_q     <= busy_d;
      reject_q   <= reject_d;
      insuff_q   <= insuff_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    vend_req_d = vend_req_q;
    reject_d   = 1'b0;
    insuff_d   = 1'b0;
    hold_d     = hold_q;
    sum        = (coin100_ev ? 5'd1 : 5'd0)
               + (coin500_ev ? 5'd5 : 5'd0);
    total      = {1'b0, credit_q} + sum;

    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // cancel > confirm > coin; a coarbitrated coin is refused
        if (cancel_ev) begin
          reject_d = coin_any;
          if (state_q == ST_CREDIT) begin
            change_d = credit_q;
            credit_d = '0;
            hold_d   = HW'(REFUND_HOLD_CYCLES);
            state_d  = ST_REFUND;
          end
        end else if (confirm_ev) begin
          reject_d = coin_any;
          if (state_q == ST_CREDIT && price != 4'd0
              && credit_q >= price) begin
            change_d   = credit_q - price;
            credit_d   = '0;
            vend_req_d = 1'b1;
            state_d    = ST_VEND;
          end else begin
            insuff_d = 1'b1;
          end
        end else if (coin_any) begin
          if (total <= 5'(MAX_CREDIT)) begin
            credit_d = total[3:0];
            state_d  = ST_CREDIT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        reject_d = coin_any;
        if (vend_ack) begin
          vend_req_d = 1'b0;
          state_d    = ST_BREW;
        end
      end
      ST_BREW: begin
        reject_d = coin_any;
        if (brew_done) begin
          change_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_REFUND: begin
        reject_d = coin_any;
        if (hold_q == '0) begin
          change_d = '0;
          state_d  = ST_IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = state_d inside {ST_VEND, ST_BREW, ST_REFUND};
  end

  assign credit       = credit_q;
  assign change       = change_q;
  assign vend_req     = vend_req_q;
  assign busy         = busy_q;
  assign reject       = reject_q;
  assign insufficient = insuff_q;
  assign state        = state_q;

endmodule
